// File: rtl/iso_tree_pkg.sv
// Shared definitions for the isolation-tree sample feeder and its benches.
package iso_tree_pkg;

   localparam int unsigned DATA_W_DEF  = 8;
   localparam int unsigned CNT_W_DEF   = 16;
   // Detector acknowledge latency in cycles after det_valid.
   localparam int unsigned DET_ACK_LAT = 3;

   // Feeder FSM encoding.
   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEND     = 2'd1,
      ST_WAIT_ACK = 2'd2,
      ST_REPORT   = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/iso_tree_sample_fifo.sv
// Synchronous FIFO buffering sensor samples ahead of the detector.
module iso_tree_sample_fifo
   import iso_tree_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] din,
   input  logic              pop,
   output logic [DATA_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic              do_push;
   logic              do_pop;

   // Extra pointer bit distinguishes full from empty when indices match.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr_q[AW-1:0]];

   // Pointer update; simultaneous push and pop both advance.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/iso_tree_sample_feeder.sv
// Feeds buffered sensor samples to the isolation-tree detector and reports verdicts.
module iso_tree_sample_feeder
   import iso_tree_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEF,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ACK_TIMEOUT = 15,
   parameter int unsigned CNT_W       = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] in_sample,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] det_data,
   output logic              det_valid,
   input  logic              det_processed,
   input  logic              det_anomaly,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_sample,
   output logic              res_anomaly,
   output logic              res_timeout,
   output logic [CNT_W-1:0]  sample_count,
   output logic [CNT_W-1:0]  anomaly_count,
   output logic              busy
);

   localparam int unsigned      TMO_W    = $clog2(ACK_TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   feeder_state_t     state_q, state_d;
   logic [DATA_W-1:0] det_data_q, det_data_d;
   logic              det_valid_q, det_valid_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_sample_q, res_sample_d;
   logic              res_anomaly_q, res_anomaly_d;
   logic              res_timeout_q, res_timeout_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [CNT_W-1:0]  sample_count_q, sample_count_d;
   logic [CNT_W-1:0]  anomaly_count_q, anomaly_count_d;
   logic              run_q;

   logic              fifo_push;
   logic              fifo_pop;
   logic [DATA_W-1:0] fifo_dout;
   logic              fifo_full;
   logic              fifo_empty;

   // run_q keeps in_ready low while reset is applied.
   assign in_ready  = run_q && !fifo_full;
   assign fifo_push = in_valid && in_ready;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;

   assign det_data      = det_data_q;
   assign det_valid     = det_valid_q;
   assign res_valid     = res_valid_q;
   assign res_sample    = res_sample_q;
   assign res_anomaly   = res_anomaly_q;
   assign res_timeout   = res_timeout_q;
   assign sample_count  = sample_count_q;
   assign anomaly_count = anomaly_count_q;

   iso_tree_sample_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .din   (in_sample),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state and registered-output values; det_valid/res_valid are set
   // one state early so they line up with SEND/REPORT.
   always_comb begin
      state_d         = state_q;
      det_data_d      = det_data_q;
      det_valid_d     = 1'b0;
      res_valid_d     = 1'b0;
      res_sample_d    = res_sample_q;
      res_anomaly_d   = res_anomaly_q;
      res_timeout_d   = res_timeout_q;
      tmo_d           = tmo_q;
      sample_count_d  = sample_count_q;
      anomaly_count_d = anomaly_count_q;
      fifo_pop        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop    = 1'b1;
               det_data_d  = fifo_dout;
               det_valid_d = 1'b1;
               state_d     = ST_SEND;
            end
         end
         ST_SEND: begin
            tmo_d   = '0;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // Acknowledge takes priority over a coincident timeout.
            if (det_processed) begin
               res_valid_d   = 1'b1;
               res_sample_d  = det_data_q;
               res_anomaly_d = det_anomaly;
               res_timeout_d = 1'b0;
               state_d       = ST_REPORT;
            end else if (tmo_q == TMO_LAST) begin
               res_valid_d   = 1'b1;
               res_sample_d  = det_data_q;
               res_anomaly_d = 1'b0;
               res_timeout_d = 1'b1;
               state_d       = ST_REPORT;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         ST_REPORT: begin
            if (sample_count_q != '1)
               sample_count_d = sample_count_q + CNT_W'(1);
            if (res_anomaly_q && (anomaly_count_q != '1))
               anomaly_count_d = anomaly_count_q + CNT_W'(1);
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         det_data_q      <= '0;
         det_valid_q     <= 1'b0;
         res_valid_q     <= 1'b0;
         res_sample_q    <= '0;
         res_anomaly_q   <= 1'b0;
         res_timeout_q   <= 1'b0;
         tmo_q           <= '0;
         sample_count_q  <= '0;
         anomaly_count_q <= '0;
         run_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         det_data_q      <= det_data_d;
         det_valid_q     <= det_valid_d;
         res_valid_q     <= res_valid_d;
         res_sample_q    <= res_sample_d;
         res_anomaly_q   <= res_anomaly_d;
         res_timeout_q   <= res_timeout_d;
         tmo_q           <= tmo_d;
         sample_count_q  <= sample_count_d;
         anomaly_count_q <= anomaly_count_d;
         run_q           <= 1'b1;
      end
   end

endmodule

// File: tb/tb_iso_tree_sample_feeder.sv
// Directed self-checking bench for iso_tree_sample_feeder.
module tb_iso_tree_sample_feeder;
   import iso_tree_pkg::*;

   localparam int unsigned DW    = 8;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TMO   = 15;
   // Narrow counters so saturation is reachable in a short run.
   localparam int unsigned CW    = 4;
   localparam int          CMAX  = 15;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [DW-1:0] in_sample = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] det_data;
   logic          det_valid;
   logic          det_processed;
   logic          det_anomaly;
   logic          res_valid;
   logic [DW-1:0] res_sample;
   logic          res_anomaly;
   logic          res_timeout;
   logic [CW-1:0] sample_count;
   logic [CW-1:0] anomaly_count;
   logic          busy;

   iso_tree_sample_feeder #(
      .DATA_W      (DW),
      .FIFO_DEPTH  (DEPTH),
      .ACK_TIMEOUT (TMO),
      .CNT_W       (CW)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_sample     (in_sample),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .det_data      (det_data),
      .det_valid     (det_valid),
      .det_processed (det_processed),
      .det_anomaly   (det_anomaly),
      .res_valid     (res_valid),
      .res_sample    (res_sample),
      .res_anomaly   (res_anomaly),
      .res_timeout   (res_timeout),
      .sample_count  (sample_count),
      .anomaly_count (anomaly_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Detector model: acknowledges DET_ACK_LAT cycles after det_valid, flags bit 7.
   logic [DET_ACK_LAT-1:0] ack_pipe = '0;
   logic                   ack_en = 1'b1;
   logic                   force_proc = 1'b0;
   always @(posedge clk) ack_pipe <= {ack_pipe[DET_ACK_LAT-2:0], det_valid};
   assign det_processed = (ack_pipe[DET_ACK_LAT-1] & ack_en) | force_proc;
   assign det_anomaly   = det_processed & det_data[7];

   typedef struct {
      logic [DW-1:0] sample;
      logic          anomaly;
      logic          timeout;
      int            cyc;
   } res_t;

   res_t          res_q[$];
   int            cyc = 0;
   int            dv_cnt = 0;
   int            dv_cyc = 0;
   logic [DW-1:0] dv_data = '0;
   int            checks = 0;
   int            errors = 0;
   int            exp_sc = 0;
   int            exp_ac = 0;
   bit            stall_seen = 1'b0;

   // Output monitor: records result strobes and det_valid pulses.
   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (res_valid) res_q.push_back('{res_sample, res_anomaly, res_timeout, cyc});
      if (det_valid) begin
         dv_cnt  <= dv_cnt + 1;
         dv_cyc  <= cyc;
         dv_data <= det_data;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic push_byte(input logic [DW-1:0] v);
      int n = 0;
      in_sample = v;
      in_valid  = 1'b1;
      while (!in_ready && n < 200) begin
         stall_seen = 1'b1;
         @(negedge clk);
         n++;
      end
      if (n >= 200) check_eq("push_wait", 32'd0, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic get_res(output res_t r);
      int n = 0;
      while (res_q.size() == 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (res_q.size() == 0) begin
         check_eq("res_wait", 32'd0, 32'd1);
         r.sample = '0; r.anomaly = 1'b0; r.timeout = 1'b0; r.cyc = 0;
      end else begin
         r = res_q.pop_front();
      end
   endtask

   task automatic bump(input bit anom);
      if (exp_sc < CMAX) exp_sc++;
      if (anom && exp_ac < CMAX) exp_ac++;
   endtask

   task automatic check_counts(input string tag);
      check_eq({tag, "_scnt"}, 32'(sample_count), 32'(exp_sc));
      check_eq({tag, "_acnt"}, 32'(anomaly_count), 32'(exp_ac));
   endtask

   task automatic run_one(input logic [DW-1:0] v, input string tag);
      res_t r;
      push_byte(v);
      get_res(r);
      check_eq({tag, "_sample"}, 32'(r.sample), 32'(v));
      check_eq({tag, "_anom"}, 32'(r.anomaly), 32'(v[7]));
      check_eq({tag, "_tmo"}, 32'(r.timeout), 32'd0);
      bump(v[7]);
      @(negedge clk);
      check_counts(tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      res_t r;
      int   d0;
      logic [DW-1:0] v;

      // Reset state
      repeat (3) @(negedge clk);
      check_eq("rst_in_ready", 32'(in_ready), 32'd0);
      check_eq("rst_det_valid", 32'(det_valid), 32'd0);
      check_eq("rst_det_data", 32'(det_data), 32'd0);
      check_eq("rst_res_valid", 32'(res_valid), 32'd0);
      check_eq("rst_res_sample", 32'(res_sample), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_counts("rst");
      reset = 1'b1;
      @(negedge clk);
      check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Single anomalous sample, latency and pulse width
      d0 = dv_cnt;
      push_byte(8'hAB);
      check_eq("t1_busy", 32'(busy), 32'd1);
      get_res(r);
      check_eq("t1_sample", 32'(r.sample), 32'hAB);
      check_eq("t1_anom", 32'(r.anomaly), 32'd1);
      check_eq("t1_tmo", 32'(r.timeout), 32'd0);
      check_eq("t1_det_data", 32'(dv_data), 32'hAB);
      check_eq("t1_dv_pulses", 32'(dv_cnt - d0), 32'd1);
      check_eq("t1_latency", 32'(r.cyc - dv_cyc), 32'(DET_ACK_LAT + 1));
      bump(1'b1);
      @(negedge clk);
      check_counts("t1");
      check_eq("t1_res_valid_pulse", 32'(res_valid), 32'd0);
      check_eq("t1_res_hold", 32'(res_sample), 32'hAB);

      // Burst with in_valid held until the FIFO back-pressures
      stall_seen = 1'b0;
      for (int i = 0; i < 6; i++) push_byte(DW'(8'h10 + i));
      check_eq("t2_stall", 32'(stall_seen), 32'd1);
      for (int i = 0; i < 6; i++) begin
         get_res(r);
         check_eq("t2_sample", 32'(r.sample), 32'(8'h10 + i));
         check_eq("t2_anom", 32'(r.anomaly), 32'd0);
         check_eq("t2_tmo", 32'(r.timeout), 32'd0);
         bump(1'b0);
      end
      @(negedge clk);
      check_counts("t2");

      // Detector silent: timeout record, then normal operation resumes
      ack_en = 1'b0;
      push_byte(8'h55);
      get_res(r);
      check_eq("t3_sample", 32'(r.sample), 32'h55);
      check_eq("t3_anom", 32'(r.anomaly), 32'd0);
      check_eq("t3_tmo", 32'(r.timeout), 32'd1);
      check_eq("t3_latency", 32'(r.cyc - dv_cyc), 32'(TMO + 1));
      bump(1'b0);
      @(negedge clk);
      check_counts("t3");
      ack_en = 1'b1;
      run_one(8'h9C, "t3_next");

      // Stray acknowledge in IDLE
      force_proc = 1'b1;
      @(negedge clk);
      force_proc = 1'b0;
      repeat (10) @(negedge clk);
      check_eq("t4_idle_nores", 32'(res_q.size()), 32'd0);
      check_eq("t4_idle_busy", 32'(busy), 32'd0);
      check_counts("t4_idle");

      // Stray acknowledge during REPORT
      push_byte(8'h21);
      d0 = 0;
      while (!res_valid && d0 < 100) begin
         @(negedge clk);
         d0++;
      end
      force_proc = 1'b1;
      @(negedge clk);
      force_proc = 1'b0;
      repeat (10) @(negedge clk);
      get_res(r);
      check_eq("t4_rep_sample", 32'(r.sample), 32'h21);
      check_eq("t4_rep_extra", 32'(res_q.size()), 32'd0);
      bump(1'b0);
      check_counts("t4_rep");

      // Reset while waiting for an acknowledge with two samples buffered
      ack_en = 1'b0;
      push_byte(8'h31);
      push_byte(8'h32);
      push_byte(8'h33);
      check_eq("t5_busy_pre", 32'(busy), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      d0 = dv_cnt;
      check_eq("t5_det_valid", 32'(det_valid), 32'd0);
      check_eq("t5_res_valid", 32'(res_valid), 32'd0);
      check_eq("t5_busy", 32'(busy), 32'd0);
      check_eq("t5_in_ready", 32'(in_ready), 32'd0);
      exp_sc = 0;
      exp_ac = 0;
      check_counts("t5");
      reset  = 1'b1;
      ack_en = 1'b1;
      @(negedge clk);
      check_eq("t5_in_ready_after", 32'(in_ready), 32'd1);
      repeat (30) @(negedge clk);
      check_eq("t5_nores", 32'(res_q.size()), 32'd0);
      check_eq("t5_no_dv", 32'(dv_cnt - d0), 32'd0);

      // Counter saturation: fill to max-1, then three anomalous samples
      for (int i = 0; i < CMAX - 1; i++) begin
         v = DW'(8'h40 + i);
         run_one(v, "t6_fill");
      end
      for (int i = 0; i < 3; i++) begin
         v = DW'(8'hC0 + i);
         run_one(v, "t6_sat");
      end
      check_eq("t6_sc_final", 32'(sample_count), 32'(CMAX));
      check_eq("t6_ac_final", 32'(anomaly_count), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
